// File: rtl/imdct_subband_scheduler.sv
// imdct_subband_scheduler
// Sequences the IMDCT stage over one compute/windowing/overlap engine shared by
// both channels: 32 subbands x 2 channels = 64 jobs, alternating ch0/ch1 per
// subband. Sideinfo is latched when the stage starts. For each job the block
// drives the channel, the granule base address (subband*18) and the effective
// block type, which accounts for mixed blocks.
//
// Optional feature: define IMDCT_SCHED_WATCHDOG_EN to enable a WAIT-state
// watchdog (WATCHDOG_CYCLES) that aborts a hung job, sets the sticky o_err
// and still completes the stage. Without the macro, o_err is tied to 0 and
// WAIT waits indefinitely.
//
// Engine handshake: o_eng_start is a single-cycle request. o_eng_channel,
// o_eng_base_addr and o_eng_block_type are valid in that cycle and stay stable
// until the next request. The engine answers with a single-cycle i_eng_done.
// i_eng_done is only honoured in WAIT; a pulse in any other state, including
// the request cycle itself, is dropped. i_stage_ready is only honoured in IDLE.
module imdct_subband_scheduler #(
  parameter int WATCHDOG_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_stage_ready,
  input  logic [1:0] i_ch0_block_type,
  input  logic [1:0] i_ch1_block_type,
  input  logic       i_ch0_window_switching_flag,
  input  logic       i_ch1_window_switching_flag,
  input  logic       i_ch0_mixed_block_flag,
  input  logic       i_ch1_mixed_block_flag,
  output logic       o_eng_start,
  output logic       o_eng_channel,
  output logic [9:0] o_eng_base_addr,
  output logic [1:0] o_eng_block_type,
  input  logic       i_eng_done,
  output logic       o_busy,
  output logic       o_stage_done,
  output logic       o_err,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic [4:0] r_subband;
  logic       r_channel;
  logic [1:0] r_ch0_bt;
  logic [1:0] r_ch1_bt;
  logic       r_ch0_ws;
  logic       r_ch1_ws;
  logic       r_ch0_mx;
  logic       r_ch1_mx;

  logic       w_accept;
  logic       w_job_done;
  logic       w_last_job;
  logic       w_timeout;

  logic       w_sel_ws;
  logic       w_sel_mx;
  logic [1:0] w_sel_bt;
  logic [9:0] w_sb_ext;

  assign w_accept   = (r_state == S_IDLE) && i_stage_ready;
  assign w_job_done = (r_state == S_WAIT) && i_eng_done;
  assign w_last_job = (r_subband == 5'd31) && r_channel;

`ifdef IMDCT_SCHED_WATCHDOG_EN
  localparam int CW = $clog2(WATCHDOG_CYCLES + 1);

  logic [CW-1:0] r_wd_cnt;
  logic          r_err;

  // Watchdog counter: cleared while issuing, counts each WAIT cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wd_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  // Abort after WATCHDOG_CYCLES WAIT cycles with no answer from the engine
  assign w_timeout = (r_state == S_WAIT) && !i_eng_done &&
                     (r_wd_cnt == CW'(WATCHDOG_CYCLES - 1));

  // Sticky error flag, cleared only when a new stage is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_stage_ready) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (i_eng_done) begin
          w_next = w_last_job ? S_DONE : S_ISSUE;
        end else if (w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register
  always_comb begin
    o_eng_start  = (r_state == S_ISSUE);
    o_busy       = (r_state != S_IDLE);
    o_stage_done = (r_state == S_DONE);
    o_dbg_state  = r_state;
  end

  // Sideinfo latch and job position (subband, channel)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_subband <= '0;
      r_channel <= 1'b0;
      r_ch0_bt  <= '0;
      r_ch1_bt  <= '0;
      r_ch0_ws  <= 1'b0;
      r_ch1_ws  <= 1'b0;
      r_ch0_mx  <= 1'b0;
      r_ch1_mx  <= 1'b0;
    end else if (w_accept) begin
      r_subband <= '0;
      r_channel <= 1'b0;
      r_ch0_bt  <= i_ch0_block_type;
      r_ch1_bt  <= i_ch1_block_type;
      r_ch0_ws  <= i_ch0_window_switching_flag;
      r_ch1_ws  <= i_ch1_window_switching_flag;
      r_ch0_mx  <= i_ch0_mixed_block_flag;
      r_ch1_mx  <= i_ch1_mixed_block_flag;
    end else if (w_job_done && !w_last_job) begin
      if (!r_channel) begin
        r_channel <= 1'b1;
      end else begin
        r_channel <= 1'b0;
        r_subband <= r_subband + 5'd1;
      end
    end
  end

  // Job descriptor: channel, base address and effective block type
  always_comb begin
    w_sel_ws = r_channel ? r_ch1_ws : r_ch0_ws;
    w_sel_mx = r_channel ? r_ch1_mx : r_ch0_mx;
    w_sel_bt = r_channel ? r_ch1_bt : r_ch0_bt;
    w_sb_ext = {5'd0, r_subband};

    o_eng_channel   = r_channel;
    // subband * 18 as a shift-add; the maximum 31*18 = 558 fits in 10 bits
    o_eng_base_addr = (w_sb_ext << 4) + (w_sb_ext << 1);

    // The two lowest subbands of a mixed block are always long blocks
    if (!w_sel_ws) begin
      o_eng_block_type = 2'd0;
    end else if (w_sel_mx && (r_subband < 5'd2)) begin
      o_eng_block_type = 2'd0;
    end else begin
      o_eng_block_type = w_sel_bt;
    end
  end

endmodule

// File: tb/tb_imdct_subband_scheduler.sv
// Testbench for imdct_subband_scheduler.
// A table of sideinfo configurations with hand-derived effective block types,
// hand-written sequences for the multi-cycle corner cases (spurious inputs,
// mid-stage reset, optional watchdog) and randomized stages checked against a
// job-list reference model built from the block's rules.
module tb_imdct_subband_scheduler;

  localparam int WD = 50;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       stage_ready;
  logic [1:0] ch0_bt, ch1_bt;
  logic       ch0_ws, ch1_ws, ch0_mx, ch1_mx;
  logic       eng_done;
  logic       eng_start, eng_channel, busy, stage_done, err;
  logic [9:0] eng_base_addr;
  logic [1:0] eng_block_type;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  imdct_subband_scheduler #(.WATCHDOG_CYCLES(WD)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .i_stage_ready               (stage_ready),
    .i_ch0_block_type            (ch0_bt),
    .i_ch1_block_type            (ch1_bt),
    .i_ch0_window_switching_flag (ch0_ws),
    .i_ch1_window_switching_flag (ch1_ws),
    .i_ch0_mixed_block_flag      (ch0_mx),
    .i_ch1_mixed_block_flag      (ch1_mx),
    .o_eng_start                 (eng_start),
    .o_eng_channel               (eng_channel),
    .o_eng_base_addr             (eng_base_addr),
    .o_eng_block_type            (eng_block_type),
    .i_eng_done                  (eng_done),
    .o_busy                      (busy),
    .o_stage_done                (stage_done),
    .o_err                       (err),
    .o_dbg_state                 (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [12:0] exp_q[$];   // {channel, base_addr[9:0], block_type[1:0]}

  // side = {bt0[1:0], ws0, mx0, bt1[1:0], ws1, mx1}
  typedef struct {
    logic [7:0] side;
    int         lat;
    logic [1:0] lo0, hi0, lo1, hi1;  // expected type for subband<2 / >=2
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_eng_start"},  eng_start,      0);
    chk({tag, "_channel"},    eng_channel,    0);
    chk({tag, "_base_addr"},  eng_base_addr,  0);
    chk({tag, "_block_type"}, eng_block_type, 0);
    chk({tag, "_busy"},       busy,           0);
    chk({tag, "_stage_done"}, stage_done,     0);
    chk({tag, "_err"},        err,            0);
  endtask

  // Reference rule for the effective block type
  function automatic logic [1:0] ref_type(input logic [1:0] bt, input logic ws,
                                          input logic mx, input int sb);
    if (!ws) return 2'd0;
    if (mx && sb < 2) return 2'd0;
    return bt;
  endfunction

  task automatic build_table_q(input vec_t v);
    logic [1:0] t;
    for (int sb = 0; sb < 32; sb++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (ch == 0) t = (sb < 2) ? v.lo0 : v.hi0;
        else         t = (sb < 2) ? v.lo1 : v.hi1;
        exp_q.push_back({ch[0], 10'(sb * 18), t});
      end
    end
  endtask

  task automatic build_model_q(input logic [7:0] s);
    logic [1:0] t;
    for (int sb = 0; sb < 32; sb++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (ch == 0) t = ref_type(s[7:6], s[5], s[4], sb);
        else         t = ref_type(s[3:2], s[1], s[0], sb);
        exp_q.push_back({ch[0], 10'(sb * 18), t});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_side(input logic [7:0] s);
    {ch0_bt, ch0_ws, ch0_mx, ch1_bt, ch1_ws, ch1_mx} = s;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  // Runs one stage. Cycle 0 is the stage_ready cycle; the bench acts as the
  // engine and answers each job lat cycles after its start (lat=0: random 1..5).
  // spur_job: spurious eng_done in that job's start cycle.
  // rst_job: one-cycle reset in the cycle after that job's start.
  // hang_job: that job is never answered (watchdog abort expected).
  task automatic run_stage(input logic [7:0] side, input int lat, input bit extra_ready,
                           input int spur_job, input int rst_job, input int hang_job,
                           input bit ready_in_done);
    int          cyc, exp_start, exp_done, j, cnt, rst_cyc, n_starts;
    bit          hung;
    logic [12:0] cur;
    drive_side(side);
    stage_ready = 1'b1;
    eng_done    = 1'b0;
    exp_start = 1; exp_done = -1; j = 0; cnt = -1; rst_cyc = -1;
    n_starts = 0; hung = 1'b0; cur = '0; cyc = 0;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      stage_ready = 1'b0;
      eng_done    = 1'b0;
      rst         = 1'b0;
      drive_side(8'($urandom));
      if (cyc > 4000) begin
        n_vec++; n_err++;
        $display("FAIL stage_budget at %0t: got %0d cycles, expected at most 4000", $time, cyc);
        break;
      end
      if (rst_cyc > 0 && cyc > rst_cyc) begin
        chk_reset("after_rst");
        if (cyc == rst_cyc + 4) break;
        continue;
      end
      chk("eng_start",  eng_start,  cyc == exp_start);
      chk("stage_done", stage_done, cyc == exp_done);
      chk("busy",       busy,       (exp_done < 0) || (cyc <= exp_done));
      chk("err",        err,        hung && (exp_done >= 0) && (cyc >= exp_done));
      if (cyc == exp_start) begin
        n_starts++;
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL job_queue at %0t: got start %0d, expected no more jobs", $time, n_starts);
        end else begin
          cur = exp_q.pop_front();
        end
        cnt = (lat > 0) ? lat : int'($urandom_range(1, 5));
        if (j == spur_job) eng_done = 1'b1;
        if (j == rst_job) begin
          rst_cyc = cyc + 1;
          cnt = -1;
        end
        if (j == hang_job) begin
          hung = 1'b1;
          exp_done = cyc + WD + 1;
          cnt = -1;
        end
        j++;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          eng_done = 1'b1;
          if (j == 64) exp_done = cyc + 1;
          else         exp_start = cyc + 1;
        end
      end
      if (n_starts > 0 && (exp_done < 0 || cyc <= exp_done)) begin
        chk("job_channel",    eng_channel,    cur[12]);
        chk("job_base_addr",  eng_base_addr,  cur[11:2]);
        chk("job_block_type", eng_block_type, cur[1:0]);
      end
      if (extra_ready && cyc == 30) stage_ready = 1'b1;
      if (cyc == rst_cyc) rst = 1'b1;
      if (ready_in_done && cyc == exp_done) stage_ready = 1'b1;
      if (exp_done >= 0 && cyc == exp_done + 1) break;
    end
    stage_ready = 1'b0;
    eng_done    = 1'b0;
    rst         = 1'b0;
    if (rst_cyc < 0) begin
      chk("job_count", n_starts, hung ? hang_job + 1 : 64);
      if (!hung) chk("jobs_left", exp_q.size(), 0);
    end
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] s;
    tbl[0] = '{{2'd2, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1}, 20, 2'd0, 2'd0, 2'd0, 2'd0};
    tbl[1] = '{{2'd2, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0},  1, 2'd0, 2'd2, 2'd3, 2'd3};
    tbl[2] = '{{2'd1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1},  3, 2'd1, 2'd1, 2'd0, 2'd0};
    tbl[3] = '{{2'd3, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1},  2, 2'd0, 2'd3, 2'd0, 2'd2};

    rst = 1'b1; stage_ready = 1'b0; eng_done = 1'b0;
    drive_side(8'hFF);
    repeat (3) @(posedge clk);
    #1;
    chk_reset("in_rst");
    rst = 1'b0;
    idle_cycle();
    chk_reset("post_rst");

    // Table-driven configurations
    for (int i = 0; i < 4; i++) begin
      build_table_q(tbl[i]);
      run_stage(tbl[i].side, tbl[i].lat, 1'b0, -1, -1, -1, 1'b0);
    end

    // Late stage_ready at cycle 30, spurious eng_done in an issue cycle,
    // stage_ready during the done cycle
    s = 8'($urandom);
    build_model_q(s);
    run_stage(s, 2, 1'b1, 7, -1, -1, 1'b1);

    // Reset during subband 10, then a clean restart
    s = 8'($urandom);
    build_model_q(s);
    run_stage(s, 0, 1'b0, -1, 20, -1, 1'b0);
    s = {2'd2, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0};
    build_model_q(s);
    run_stage(s, 1, 1'b0, -1, -1, -1, 1'b0);

    // Randomized stages against the reference model
    for (int i = 0; i < 5; i++) begin
      s = 8'($urandom);
      build_model_q(s);
      run_stage(s, 0, 1'b0, -1, -1, -1, 1'b0);
    end

`ifdef IMDCT_SCHED_WATCHDOG_EN
    // Engine never answers job 5: abort, err held, cleared by next stage
    s = 8'($urandom);
    build_model_q(s);
    run_stage(s, 2, 1'b0, -1, -1, 5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      chk("err_held", err, 1);
      chk("idle_busy", busy, 0);
    end
    s = 8'($urandom);
    build_model_q(s);
    run_stage(s, 3, 1'b0, -1, -1, -1, 1'b0);
`endif

    idle_cycle();
    chk("final_busy", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout at %0t: got no finish, expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
